// File: rtl/reservation_pool_if.sv
// Handshake bundle between the MPU allocator (master) and the reservation-ID pool (slave).
interface reservation_pool_if #(
  parameter int ID_W = 4
);
  logic            reservation_dequeue;
  logic            release_valid;
  logic [ID_W-1:0] release_id;
  logic [ID_W-1:0] reservation_id;
  logic            reservation_valid;
  logic            empty;
  logic [ID_W:0]   avail_count;
  logic            err_underflow;
  logic            err_release;

  modport master (
    output reservation_dequeue, release_valid, release_id,
    input  reservation_id, reservation_valid, empty, avail_count,
           err_underflow, err_release
  );

  modport slave (
    input  reservation_dequeue, release_valid, release_id,
    output reservation_id, reservation_valid, empty, avail_count,
           err_underflow, err_release
  );
endinterface

// File: rtl/reservation_pool.sv
// Reservation-ID pool: never-issued IDs come from a fresh counter first,
// returned IDs are recycled through a FIFO; same-cycle release feeds an empty pool directly.
module reservation_pool #(
  parameter int BLOCK_COUNT      = 16,
  parameter int BLOCK_COUNT_BITS = $clog2(BLOCK_COUNT)
) (
  input logic              clk,
  input logic              rst_n,
  reservation_pool_if.slave pool_if
);
  localparam int CW = BLOCK_COUNT_BITS + 1;
  localparam logic [CW-1:0]               BC_C    = CW'(BLOCK_COUNT);
  localparam logic [CW-1:0]               CNT_ONE = CW'(1);
  localparam logic [BLOCK_COUNT_BITS-1:0] PTR_ONE = BLOCK_COUNT_BITS'(1);

  logic [CW-1:0]               fresh_cnt_q, fresh_cnt_d;
  logic [CW-1:0]               fifo_cnt_q, fifo_cnt_d;
  logic [BLOCK_COUNT_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [BLOCK_COUNT_BITS-1:0] wr_ptr_q, wr_ptr_d;
  logic [BLOCK_COUNT_BITS-1:0] res_id_q, res_id_d;
  logic                        res_valid_q, res_valid_d;
  logic                        err_underflow_q, err_underflow_d;
  logic                        err_release_q, err_release_d;
  logic [BLOCK_COUNT_BITS-1:0] mem [BLOCK_COUNT];

  logic [CW-1:0] avail;
  logic          pool_empty;
  logic          fresh_avail;
  logic          fifo_nonempty;
  logic          fifo_full;
  logic          id_issued;
  logic          bypass;
  logic          pop_fresh;
  logic          pop_fifo;
  logic          rel_accept;

  assign avail         = (BC_C - fresh_cnt_q) + fifo_cnt_q;
  assign pool_empty    = (avail == '0);
  assign fresh_avail   = (fresh_cnt_q < BC_C);
  assign fifo_nonempty = (fifo_cnt_q != '0);
  assign fifo_full     = (fifo_cnt_q == BC_C);
  assign id_issued     = ({1'b0, pool_if.release_id} < fresh_cnt_q);

  // An empty pool can still serve a pop if a valid ID is returned in the same cycle.
  assign bypass     = pool_if.reservation_dequeue & pool_if.release_valid & pool_empty & id_issued;
  assign pop_fresh  = pool_if.reservation_dequeue & fresh_avail;
  assign pop_fifo   = pool_if.reservation_dequeue & ~fresh_avail & fifo_nonempty;
  assign rel_accept = pool_if.release_valid & id_issued & ~fifo_full & ~bypass;

  always_comb begin
    fresh_cnt_d     = fresh_cnt_q;
    fifo_cnt_d      = fifo_cnt_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    res_id_d        = res_id_q;
    res_valid_d     = res_valid_q;
    err_underflow_d = 1'b0;
    err_release_d   = pool_if.release_valid & ~bypass & (~id_issued | fifo_full);

    if (pool_if.reservation_dequeue) begin
      if (pop_fresh) begin
        res_id_d    = fresh_cnt_q[BLOCK_COUNT_BITS-1:0];
        res_valid_d = 1'b1;
        fresh_cnt_d = fresh_cnt_q + CNT_ONE;
      end else if (pop_fifo) begin
        res_id_d    = mem[rd_ptr_q];
        res_valid_d = 1'b1;
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
      end else if (bypass) begin
        res_id_d    = pool_if.release_id;
        res_valid_d = 1'b1;
      end else begin
        res_valid_d     = 1'b0;
        err_underflow_d = 1'b1;
      end
    end

    if (rel_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_ONE;
    end

    fifo_cnt_d = fifo_cnt_q + (rel_accept ? CNT_ONE : '0) - (pop_fifo ? CNT_ONE : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fresh_cnt_q     <= '0;
      fifo_cnt_q      <= '0;
      rd_ptr_q        <= '0;
      wr_ptr_q        <= '0;
      res_id_q        <= '0;
      res_valid_q     <= 1'b0;
      err_underflow_q <= 1'b0;
      err_release_q   <= 1'b0;
    end else begin
      fresh_cnt_q     <= fresh_cnt_d;
      fifo_cnt_q      <= fifo_cnt_d;
      rd_ptr_q        <= rd_ptr_d;
      wr_ptr_q        <= wr_ptr_d;
      res_id_q        <= res_id_d;
      res_valid_q     <= res_valid_d;
      err_underflow_q <= err_underflow_d;
      err_release_q   <= err_release_d;
    end
  end

  // Storage is deliberately unreset; the pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (rel_accept) begin
      mem[wr_ptr_q] <= pool_if.release_id;
    end
  end

  assign pool_if.reservation_id    = res_id_q;
  assign pool_if.reservation_valid = res_valid_q;
  assign pool_if.empty             = pool_empty;
  assign pool_if.avail_count       = avail;
  assign pool_if.err_underflow     = err_underflow_q;
  assign pool_if.err_release       = err_release_q;
endmodule

// File: tb/tb_reservation_pool.sv
// Directed self-checking bench for reservation_pool.
module tb_reservation_pool;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_fail;

  reservation_pool_if #(.ID_W(4)) pif ();

  reservation_pool #(.BLOCK_COUNT(16), .BLOCK_COUNT_BITS(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .pool_if (pif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_outs(input string tag, input logic [3:0] id, input logic vld,
                          input logic [4:0] avail, input logic emp,
                          input logic uf, input logic rel);
    chk({tag, ".id"},    32'(pif.reservation_id),    32'(id));
    chk({tag, ".valid"}, 32'(pif.reservation_valid), 32'(vld));
    chk({tag, ".avail"}, 32'(pif.avail_count),       32'(avail));
    chk({tag, ".empty"}, 32'(pif.empty),             32'(emp));
    chk({tag, ".uf"},    32'(pif.err_underflow),     32'(uf));
    chk({tag, ".rel"},   32'(pif.err_release),       32'(rel));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    pif.reservation_dequeue = 1'b0;
    pif.release_valid       = 1'b0;
    pif.release_id          = 4'd0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    tick();
    chk_outs("reset", 4'd0, 1'b0, 5'd16, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Sequential fresh pops 0..15
    pif.reservation_dequeue = 1'b1;
    for (int i = 0; i < 16; i++) begin
      tick();
      chk("seq.id",    32'(pif.reservation_id),    32'(i));
      chk("seq.valid", 32'(pif.reservation_valid), 32'd1);
      chk("seq.avail", 32'(pif.avail_count),       32'(15 - i));
    end
    chk("seq.empty", 32'(pif.empty), 32'd1);

    // Underflow
    tick();
    chk_outs("uflow", 4'd15, 1'b0, 5'd0, 1'b1, 1'b1, 1'b0);
    pif.reservation_dequeue = 1'b0;
    tick();
    chk("uflow.clear", 32'(pif.err_underflow), 32'd0);

    // Recycle order
    pif.release_valid = 1'b1;
    pif.release_id = 4'd7;  tick(); chk("rec.rel7",  32'(pif.avail_count), 32'd1);
    pif.release_id = 4'd3;  tick(); chk("rec.rel3",  32'(pif.avail_count), 32'd2);
    pif.release_id = 4'd11; tick(); chk("rec.rel11", 32'(pif.avail_count), 32'd3);
    chk("rec.noerr", 32'(pif.err_release), 32'd0);
    pif.release_valid = 1'b0;
    pif.reservation_dequeue = 1'b1;
    tick(); chk_outs("rec.pop0", 4'd7,  1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    tick(); chk_outs("rec.pop1", 4'd3,  1'b1, 5'd1, 1'b0, 1'b0, 1'b0);
    tick(); chk_outs("rec.pop2", 4'd11, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);

    // Bypass on empty pool
    pif.release_valid = 1'b1;
    pif.release_id = 4'd9;
    tick();
    chk_outs("bypass", 4'd9, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
    pif.reservation_dequeue = 1'b0;
    pif.release_valid = 1'b0;

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk_outs("areset", 4'd0, 1'b0, 5'd16, 1'b0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;

    // Fresh priority over recycled IDs
    pif.reservation_dequeue = 1'b1;
    tick(); chk("fp.pop0", 32'(pif.reservation_id), 32'd0);
    pif.reservation_dequeue = 1'b0;
    pif.release_valid = 1'b1;
    pif.release_id = 4'd0;
    tick(); chk("fp.rel0", 32'(pif.avail_count), 32'd16);
    pif.release_valid = 1'b0;
    pif.reservation_dequeue = 1'b1;
    tick(); chk_outs("fp.pop1", 4'd1, 1'b1, 5'd15, 1'b0, 1'b0, 1'b0);
    pif.reservation_dequeue = 1'b0;

    // Invalid release of a never-issued ID
    do_reset();
    pif.reservation_dequeue = 1'b1;
    tick(); chk("ir.pop0", 32'(pif.reservation_id), 32'd0);
    tick(); chk("ir.pop1", 32'(pif.reservation_id), 32'd1);
    pif.reservation_dequeue = 1'b0;
    pif.release_valid = 1'b1;
    pif.release_id = 4'd5;
    tick(); chk_outs("ir.rel5", 4'd1, 1'b1, 5'd14, 1'b0, 1'b0, 1'b1);
    pif.release_id = 4'd1;
    tick(); chk_outs("ir.rel1", 4'd1, 1'b1, 5'd15, 1'b0, 1'b0, 1'b0);

    // Simultaneous pop and release on a non-empty pool: fresh pop, FIFO grows
    pif.reservation_dequeue = 1'b1;
    pif.release_id = 4'd0;
    tick(); chk_outs("sim", 4'd2, 1'b1, 5'd15, 1'b0, 1'b0, 1'b0);
    pif.reservation_dequeue = 1'b0;
    pif.release_valid = 1'b0;
    tick(); chk_outs("idle", 4'd2, 1'b1, 5'd15, 1'b0, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/reservation_pool.md
# reservation_pool

Source of reservation IDs for the MPU allocator. It hands out one unique `BLOCK_COUNT_BITS`-wide reservation ID per allocation when `malloc` pulses `reservation_dequeue`. It takes IDs back from the free/deallocation path through a release port. IDs never yet issued come from a fresh counter; returned IDs are recycled through an internal FIFO. No initialisation sweep is needed after reset.

## Interface
- `BLOCK_COUNT`, 16, number of ACT entries; also the size of the reservation-ID space (IDs 0..BLOCK_COUNT-1)
- `BLOCK_COUNT_BITS`, 4, $clog2(BLOCK_COUNT); width of a reservation ID
- `clk`  in  1  clock; all state changes on the rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `reservation_dequeue`  in  1  pop request from `malloc`; one pop per cycle sampled high
- `release_valid`  in  1  return one ID to the pool this cycle
- `release_id`  in  BLOCK_COUNT_BITS  ID being returned
- `reservation_id`  out  BLOCK_COUNT_BITS  registered ID from the last successful pop; holds until the next pop
- `reservation_valid`  out  1  high when `reservation_id` holds a successfully popped ID
- `empty`  out  1  no ID available (fresh counter exhausted and FIFO empty)
- `avail_count`  out  BLOCK_COUNT_BITS+1  number of IDs available
- `err_underflow`  out  1  one-cycle pulse: pop while empty and no bypass
- `err_release`  out  1  one-cycle pulse: release rejected (FIFO full or ID never issued)

## Operation
- **State**
  - `fresh_cnt`: BLOCK_COUNT_BITS+1 wide, 0..BLOCK_COUNT. It is the next never-issued ID.
  - Recycle FIFO: depth BLOCK_COUNT, with `rd_ptr` and `wr_ptr` (BLOCK_COUNT_BITS wide, wrap modulo BLOCK_COUNT) and `fifo_cnt` (BLOCK_COUNT_BITS+1 wide).
- **Pop priority**: the fresh counter is used first, the FIFO second. Fresh-first maximises the time before an ID is reused.
  - If `fresh_cnt` < BLOCK_COUNT: `reservation_id` <= `fresh_cnt[BLOCK_COUNT_BITS-1:0]`, `fresh_cnt`++.
  - Else if `fifo_cnt` > 0: `reservation_id` <= `mem[rd_ptr]`, `rd_ptr`++, `fifo_cnt`--.
  - Else, if the bypass condition holds, the bypass applies.
  - Else: `err_underflow` pulses, `reservation_valid` <= 0, and `reservation_id` is held.
  - Every successful pop sets `reservation_valid` <= 1.
- **Release acceptance**
  - A release is rejected (`err_release` pulse, no state change) if `release_id` >= `fresh_cnt`, i.e. the ID was never issued.
  - It is also rejected if `fifo_cnt` == BLOCK_COUNT and the release is not being consumed by the bypass.
  - Otherwise: `mem[wr_ptr]` <= `release_id`, `wr_ptr`++, `fifo_cnt`++.
- **Bypass**: applies when pop and release occur in the same cycle while `empty` = 1 and the release is otherwise valid.
  - `reservation_id` <= `release_id` and `reservation_valid` <= 1.
  - The FIFO is untouched and no error is raised.
- **Simultaneous pop and release, not empty**: both are performed in the same cycle; `fifo_cnt` changes by the net amount.
- `avail_count` = (BLOCK_COUNT − `fresh_cnt`) + `fifo_cnt`. It is combinational from registers; `empty` = (`avail_count` == 0).
- Duplicate releases of an already-returned ID are not detected; the free path guarantees uniqueness.

## Timing
- **Reset** (async assert, takes effect immediately): `fresh_cnt`=0, pointers=0, `fifo_cnt`=0, `reservation_id`=0, `reservation_valid`=0, `err_underflow`=0, `err_release`=0. Hence `avail_count`=BLOCK_COUNT and `empty`=0. FIFO contents are not reset.
- **Reset deassertion**: the pool is usable the first edge after deassertion; there is no init latency.
- **Pop latency**: `reservation_dequeue` sampled high at edge N gives the new `reservation_id`/`reservation_valid` visible after edge N.
  - `malloc` raises dequeue for one cycle and samples `reservation_id` one cycle after that, so the value is stable in time.
- **Release**: takes effect at the sampling edge. A popped-then-released ID is poppable from the next cycle.
- **Error flags**: `err_*` are registered, high exactly one cycle per offending request, and cleared the next edge unless repeated.
- **Dequeue level**: a dequeue held high for K cycles performs K pops.
- **Reset mid-operation**: all counters are cleared immediately and all IDs are considered unissued. Downstream owners must also be reset.

## Test plan
- **Reset then sequential pops**: after reset, 16 single-cycle dequeues -> `reservation_id` 0,1,…,15 each one cycle after its pop, `avail_count` 16→0, `empty`=1 after the last pop.
- **Underflow**: with the pool empty, pulse dequeue -> `err_underflow`=1 for one cycle, `reservation_valid`=0, `reservation_id` stays 15.
- **Recycle order**: with the pool empty, release 7, 3, 11 on consecutive cycles, then pop 3 times -> IDs 7, 3, 11 in order; `avail_count` goes 3→0.
- **Fresh priority**: after reset, pop (0), release 0, pop -> `reservation_id`=1 rather than 0; `avail_count`=15.
- **Invalid release**: after reset and two pops (0,1), release 5 -> `err_release` pulse, `avail_count` stays 14. Then release 1 -> accepted, `avail_count`=15.
- **Bypass and async reset**:
  - Empty pool, same cycle dequeue + release 9 -> `reservation_id`=9, `reservation_valid`=1, no error, `avail_count`=0.
  - Then assert `rst_n`=0 between clock edges -> all outputs at reset values before the next edge.
